// File: rtl/twos_comp_pipe.sv
// twos_comp_pipe
//   Pipelined two's-complement unit (pass / negate / abs / ones-complement).
//   The +1 carry ripples through one CHUNK of the result per pipeline stage,
//   so the critical path stays at one CHUNK-bit add no matter how wide WIDTH is.
//   Latency is STAGES = ceil(WIDTH/CHUNK) cycles. The unit has valid/ready flow
//   control with a global stall: every stage holds while a result waits for the
//   consumer.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand valid
//   in_ready   out  1      operand accepted this cycle when in_valid is high
//   in_mode    in   2      00 pass, 01 negate, 10 abs, 11 ones-complement
//   in_data    in   WIDTH  operand (two's complement)
//   in_tag     in   TAG_W  sideband, returned unchanged with the result
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes the result
//   out_data   out  WIDTH  result
//   out_tag    out  TAG_W  tag belonging to out_data
//   out_ovf    out  1      negate/abs of the most negative value (result wraps)

module twos_comp_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf
);

  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic                advance;
  logic [STAGES-1:0]   valid_q;
  logic [WIDTH-1:0]    data_q [STAGES];
  logic [WIDTH-1:0]    data_d [STAGES];
  logic [STAGES-1:0]   carry_q;
  logic [STAGES-1:0]   carry_d;
  logic [TAG_W-1:0]    tag_q [STAGES];
  logic [STAGES-1:0]   ovf_q;

  // Mode decode: the whole operand is inverted up front, and the +1 needed
  // for negation enters as the carry into chunk 0.
  logic             inv;
  logic             cin0;
  logic             ovf0;
  logic [WIDTH-1:0] operand;

  assign inv     = (in_mode == 2'b01) | ((in_mode == 2'b10) & in_data[WIDTH-1]) |
                   (in_mode == 2'b11);
  assign cin0    = inv & (in_mode != 2'b11);
  assign ovf0    = (in_data == MIN_VAL) & ((in_mode == 2'b01) | (in_mode == 2'b10));
  assign operand = in_data ^ {WIDTH{inv}};

  // Stage k resolves bits [LO +: CW]; the bits above travel along untouched
  // (already inverted) until their own stage adds the incoming carry.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int CW = ((WIDTH - LO) < CHUNK) ? (WIDTH - LO) : CHUNK;
    localparam logic [WIDTH-1:0] MASK = ((WIDTH'(1) << CW) - WIDTH'(1)) << LO;

    logic [WIDTH-1:0] src;
    logic             cin;
    logic [CW:0]      sum;

    if (k == 0) begin : g_first
      assign src = operand;
      assign cin = cin0;
    end else begin : g_next
      assign src = data_q[k-1];
      assign cin = carry_q[k-1];
    end

    assign sum        = {1'b0, src[LO +: CW]} + {{CW{1'b0}}, cin};
    assign data_d[k]  = (src & ~MASK) | (WIDTH'(sum[CW-1:0]) << LO);
    assign carry_d[k] = sum[CW];
  end

  // Global stall: the pipeline only moves when the output slot is free or
  // being drained this cycle.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else if (advance) begin
      valid_q[0] <= in_valid;
      tag_q[0]   <= in_tag;
      ovf_q[0]   <= ovf0;
      carry_q    <= carry_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        tag_q[k]   <= tag_q[k-1];
        ovf_q[k]   <= ovf_q[k-1];
      end
    end
  end

  // Carry out of the top chunk is dropped: results are modulo 2^WIDTH.
  logic unused_carry;
  assign unused_carry = carry_q[STAGES-1];

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign out_ovf   = ovf_q[STAGES-1];

endmodule
